// File: rtl/seg_scan_8digit.sv
// Eight-digit multiplexed 7-segment scanner: per-slot prescaler, digit index,
// frame-latched shadow copies of the inputs, and registered anode/segment drive.
module seg_scan_8digit #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bcd_in,
  input  logic [7:0]  dp_in,
  input  logic        blank_en,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] pcnt;
  logic [2:0]    idx;
  logic [31:0]   shadow_bcd;
  logic [7:0]    shadow_dp;
  logic          shadow_blank;

  logic          tick;
  logic          frame_edge;
  logic [3:0]    nibble;
  logic [31:0]   upper;
  logic [6:0]    glyph;
  logic [7:0]    seg_next;

  assign tick       = (pcnt == PW'(CLK_DIV - 1));
  assign frame_edge = tick && (idx == 3'd7);

  function automatic logic [6:0] bcd_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = 7'h3F;
    endcase
    return g;
  endfunction

  // A digit is a leading zero when it and every digit above it are zero;
  // non-BCD nibbles count as non-zero, so they are never blanked.
  always_comb begin
    nibble = shadow_bcd[{idx, 2'b00} +: 4];
    upper  = shadow_bcd >> {idx, 2'b00};
    glyph  = bcd_glyph(nibble);
    if (shadow_blank && (idx != 3'd0) && (upper == 32'd0)) begin
      glyph = 7'h7F;
    end
    seg_next = {~shadow_dp[idx], glyph};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt         <= '0;
      idx          <= 3'd0;
      shadow_bcd   <= 32'd0;
      shadow_dp    <= 8'd0;
      shadow_blank <= 1'b0;
      an           <= 8'hFF;
      seg          <= 8'hFF;
      frame_done   <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      if (tick) begin
        idx <= idx + 3'd1;
      end
      // Inputs are only captured here, so a frame is never torn mid-scan.
      if (frame_edge) begin
        shadow_bcd   <= bcd_in;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_en;
      end
      frame_done <= frame_edge;
      an         <= ~(8'b1 << idx);
      seg        <= seg_next;
    end
  end

endmodule
